config_loader: RTL and testbench

//  Configuration writer for the fabric scan chain. Accepts bitstream words over a

---
 rtl/config_loader_pkg.sv | 16 +
 rtl/config_loader_piso_shreg.sv | 33 +++
 rtl/config_loader.sv | 139 +++++++++++++
 tb/tb_config_loader.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/config_loader_pkg.sv
// Shared definitions for the scan-chain configuration loader: FSM encoding and
// the default chain length derived from the fabric geometry.
package config_loader_pkg;

    localparam int CLB_NUM       = 10;
    localparam int LUT_WIDTH     = 4;
    localparam int DEF_CHAIN_LEN = CLB_NUM * (2 ** LUT_WIDTH);

    typedef enum logic [1:0] {
        LD_IDLE  = 2'd0,
        LD_WAIT  = 2'd1,
        LD_SHIFT = 2'd2,
        LD_DONE  = 2'd3
    } ld_state_e;

endpackage

// File: rtl/config_loader_piso_shreg.sv
// Parallel-load, serial-out shift register; o_serial is the MSB of the held word.
module piso_shreg #(
    parameter int WORD_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clr,
    input  logic                  i_load,
    input  logic                  i_shift,
    input  logic [WORD_WIDTH-1:0] i_data,
    output logic                  o_serial
);

    logic [WORD_WIDTH-1:0] r_sreg;

    // Word storage: clear discards any unsent bits so the serial line idles low.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sreg <= '0;
        end else if (i_clr) begin
            r_sreg <= '0;
        end else if (i_load) begin
            r_sreg <= i_data;
        end else if (i_shift) begin
            r_sreg <= {r_sreg[WORD_WIDTH-2:0], 1'b0};
        end else begin
            r_sreg <= r_sreg;
        end
    end

    assign o_serial = r_sreg[WORD_WIDTH-1];

endmodule

// File: rtl/config_loader.sv
// Bitstream-to-scan-chain loader: accepts words on a valid/ready handshake and
// shifts exactly CHAIN_LEN bits MSB-first into the fabric scan chain.
module config_loader
    import config_loader_pkg::*;
#(
    parameter int WORD_WIDTH = 8,
    parameter int CHAIN_LEN  = DEF_CHAIN_LEN,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [WORD_WIDTH-1:0] i_word_in,
    input  logic                  i_word_valid,
    output logic                  o_word_ready,
    output logic                  o_scan_en,
    output logic                  o_scan_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [CNT_WIDTH-1:0]  o_bit_count
);

    localparam int                   WB_WIDTH   = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
    localparam logic [CNT_WIDTH-1:0] LAST_CHAIN = CNT_WIDTH'(CHAIN_LEN);
    localparam logic [WB_WIDTH-1:0]  LAST_WBIT  = WB_WIDTH'(WORD_WIDTH - 1);

    ld_state_e            r_state;
    ld_state_e            w_next;
    logic [CNT_WIDTH-1:0] r_bit_count;
    logic [CNT_WIDTH-1:0] w_bit_count_nxt;
    logic [CNT_WIDTH-1:0] w_bit_count_inc;
    logic [WB_WIDTH-1:0]  r_wbit;
    logic [WB_WIDTH-1:0]  w_wbit_nxt;
    logic                 r_word_ready;
    logic                 r_scan_en;
    logic                 r_busy;
    logic                 r_done;
    logic                 w_load;
    logic                 w_shift;
    logic                 w_clr;
    logic                 w_serial;

    assign w_bit_count_inc = r_bit_count + CNT_WIDTH'(1);

    // Next-state, counter updates and shift-register controls.
    always_comb begin
        w_next          = r_state;
        w_bit_count_nxt = r_bit_count;
        w_wbit_nxt      = r_wbit;
        w_load          = 1'b0;
        w_shift         = 1'b0;
        case (r_state)
            LD_IDLE: begin
                if (i_start && !i_abort) begin
                    w_next          = LD_WAIT;
                    w_bit_count_nxt = '0;
                end else begin
                    w_next = LD_IDLE;
                end
            end
            LD_WAIT: begin
                if (i_abort) begin
                    w_next = LD_IDLE;
                end else if (i_word_valid) begin
                    w_next     = LD_SHIFT;
                    w_load     = 1'b1;
                    w_wbit_nxt = '0;
                end else begin
                    w_next = LD_WAIT;
                end
            end
            LD_SHIFT: begin
                // The bit on scan_data this cycle reaches the fabric even when aborting.
                w_bit_count_nxt = w_bit_count_inc;
                w_wbit_nxt      = r_wbit + WB_WIDTH'(1);
                if (i_abort) begin
                    w_next = LD_IDLE;
                end else if (w_bit_count_inc == LAST_CHAIN) begin
                    w_next = LD_DONE;
                end else if (r_wbit == LAST_WBIT) begin
                    w_next = LD_WAIT;
                end else begin
                    w_next  = LD_SHIFT;
                    w_shift = 1'b1;
                end
            end
            LD_DONE: begin
                w_next = LD_IDLE;
            end
            default: begin
                w_next = LD_IDLE;
            end
        endcase
    end

    assign w_clr = (w_next != LD_SHIFT);

    // State, counters and outputs, all registered from the next state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= LD_IDLE;
            r_bit_count  <= '0;
            r_wbit       <= '0;
            r_word_ready <= 1'b0;
            r_scan_en    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_bit_count  <= w_bit_count_nxt;
            r_wbit       <= w_wbit_nxt;
            r_word_ready <= (w_next == LD_WAIT);
            r_scan_en    <= (w_next == LD_SHIFT);
            r_busy       <= (w_next != LD_IDLE);
            r_done       <= (w_next == LD_DONE);
        end
    end

    piso_shreg #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_piso (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clr    (w_clr),
        .i_load   (w_load),
        .i_shift  (w_shift),
        .i_data   (i_word_in),
        .o_serial (w_serial)
    );

    assign o_word_ready = r_word_ready;
    assign o_scan_en    = r_scan_en;
    assign o_scan_data  = w_serial;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_bit_count  = r_bit_count;

endmodule

// File: tb/tb_config_loader.sv
// Directed bench: two loaders (16- and 20-bit chains) each feeding a behavioural scan chain.
module tb_config_loader;

    localparam int WW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, abort, valid, start_a, start_b, src_clr;
    logic [WW-1:0] src_words [0:7];
    logic [2:0]    idx_a, idx_b;
    logic [WW-1:0] word_a, word_b;
    logic          ready_a, scan_en_a, scan_data_a, busy_a, done_a;
    logic          ready_b, scan_en_b, scan_data_b, busy_b, done_b;
    logic [7:0]    cnt_a, cnt_b;
    logic [15:0]   chain_a;
    logic [19:0]   chain_b;
    int            acc_a, acc_b, en_a, en_b, dones_a, dones_b;
    int            checks = 0;
    int            errors = 0;

    assign word_a = src_words[idx_a];
    assign word_b = src_words[idx_b];

    config_loader #(.WORD_WIDTH(WW), .CHAIN_LEN(16), .CNT_WIDTH(8)) u_dut_a (
        .i_clk(clk), .i_rst(rst), .i_start(start_a), .i_abort(abort),
        .i_word_in(word_a), .i_word_valid(valid), .o_word_ready(ready_a),
        .o_scan_en(scan_en_a), .o_scan_data(scan_data_a), .o_busy(busy_a),
        .o_done(done_a), .o_bit_count(cnt_a)
    );

    config_loader #(.WORD_WIDTH(WW), .CHAIN_LEN(20), .CNT_WIDTH(8)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(start_b), .i_abort(abort),
        .i_word_in(word_b), .i_word_valid(valid), .o_word_ready(ready_b),
        .o_scan_en(scan_en_b), .o_scan_data(scan_data_b), .o_busy(busy_b),
        .o_done(done_b), .o_bit_count(cnt_b)
    );

    // Word sources, handshake counters and behavioural fabric scan chains.
    always @(posedge clk) begin
        if (src_clr) begin
            idx_a <= 3'd0; idx_b <= 3'd0;
            acc_a <= 0; acc_b <= 0; en_a <= 0; en_b <= 0;
            dones_a <= 0; dones_b <= 0;
            chain_a <= 16'h0000; chain_b <= 20'h00000;
        end else begin
            if (valid && ready_a) begin idx_a <= idx_a + 3'd1; acc_a <= acc_a + 1; end
            if (valid && ready_b) begin idx_b <= idx_b + 3'd1; acc_b <= acc_b + 1; end
            if (scan_en_a) begin chain_a <= {chain_a[14:0], scan_data_a}; en_a <= en_a + 1; end
            if (scan_en_b) begin chain_b <= {chain_b[18:0], scan_data_b}; en_b <= en_b + 1; end
            if (done_a) dones_a <= dones_a + 1;
            if (done_b) dones_b <= dones_b + 1;
        end
    end

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic restart_src();
        valid   = 1'b0;
        src_clr = 1'b1;
        tick(1);
        src_clr = 1'b0;
    endtask

    initial begin
        int n;
        int gap_hi;
        rst = 1'b1; abort = 1'b0; valid = 1'b0; start_a = 1'b0; start_b = 1'b0; src_clr = 1'b1;
        for (int i = 0; i < 8; i++) src_words[i] = 8'h00;
        tick(3);
        check("rst_ready", 32'(ready_a), 32'd0);
        check("rst_scan_en", 32'(scan_en_a), 32'd0);
        check("rst_scan_data", 32'(scan_data_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_bit_count", 32'(cnt_a), 32'd0);
        rst = 1'b0;

        // Test 1: two words back to back on a 16-bit chain
        src_words[0] = 8'hA5; src_words[1] = 8'h3C;
        restart_src();
        valid = 1'b1; start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        check("t1_busy_after_start", 32'(busy_a), 32'd1);
        check("t1_ready_after_start", 32'(ready_a), 32'd1);
        n = 1;
        while (!done_a && n < 60) begin tick(1); n++; end
        check("t1_done_cycle", n, 32'd19);
        check("t1_chain", 32'(chain_a), 32'hA53C);
        check("t1_scan_en_cycles", en_a, 32'd16);
        check("t1_words", acc_a, 32'd2);
        check("t1_bit_count", 32'(cnt_a), 32'd16);
        tick(1);
        check("t1_done_one_cycle", 32'(done_a), 32'd0);
        check("t1_idle", 32'(busy_a), 32'd0);
        check("t1_count_hold", 32'(cnt_a), 32'd16);
        check("t1_done_pulses", dones_a, 32'd1);

        // Test 2: 20-bit chain, third word only partly used
        src_words[0] = 8'hFF; src_words[1] = 8'h00; src_words[2] = 8'hB7;
        restart_src();
        valid = 1'b1; start_b = 1'b1;
        tick(1);
        start_b = 1'b0;
        n = 0;
        while (!done_b && n < 100) begin tick(1); n++; end
        check("t2_done_seen", 32'(done_b), 32'd1);
        check("t2_chain", 32'(chain_b), 32'h000FF00B);
        check("t2_words", acc_b, 32'd3);
        check("t2_scan_en_cycles", en_b, 32'd20);
        check("t2_bit_count", 32'(cnt_b), 32'd20);
        valid = 1'b0;
        tick(2);
        check("t2_no_extra_word", acc_b, 32'd3);

        // Test 3: source stall between words
        src_words[0] = 8'hA5; src_words[1] = 8'h3C;
        restart_src();
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        valid = 1'b1;
        n = 0;
        while (acc_a == 0 && n < 20) begin tick(1); n++; end
        valid = 1'b0;
        check("t3_first_accept", acc_a, 32'd1);
        n = 0;
        while (!ready_a && n < 20) begin tick(1); n++; end
        check("t3_wait_again", 32'(ready_a), 32'd1);
        gap_hi = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (scan_en_a) gap_hi++;
        end
        check("t3_gap_scan_en_low", gap_hi, 32'd0);
        check("t3_gap_no_accept", acc_a, 32'd1);
        valid = 1'b1;
        n = 0;
        while (!done_a && n < 40) begin tick(1); n++; end
        check("t3_done_seen", 32'(done_a), 32'd1);
        check("t3_chain", 32'(chain_a), 32'hA53C);
        check("t3_bit_count", 32'(cnt_a), 32'd16);
        check("t3_scan_en_cycles", en_a, 32'd16);
        valid = 1'b0;
        tick(1);

        // Test 4: abort part-way, then a clean reload
        restart_src();
        valid = 1'b1; start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        n = 0;
        while (cnt_a != 8'd9 && n < 40) begin tick(1); n++; end
        check("t4_reach_9", 32'(cnt_a), 32'd9);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("t4_abort_busy", 32'(busy_a), 32'd0);
        check("t4_abort_scan_en", 32'(scan_en_a), 32'd0);
        check("t4_abort_ready", 32'(ready_a), 32'd0);
        check("t4_abort_count", 32'(cnt_a), 32'd10);
        check("t4_abort_fabric_bits", en_a, 32'd10);
        tick(3);
        check("t4_no_done", dones_a, 32'd0);
        check("t4_count_hold", 32'(cnt_a), 32'd10);
        restart_src();
        valid = 1'b1; start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        n = 0;
        while (!done_a && n < 40) begin tick(1); n++; end
        check("t4_reload_done", 32'(done_a), 32'd1);
        check("t4_reload_chain", 32'(chain_a), 32'hA53C);
        check("t4_reload_count", 32'(cnt_a), 32'd16);
        valid = 1'b0;
        tick(1);

        // Test 5: start ignored while busy, valid ignored while not ready, start+abort in IDLE
        restart_src();
        valid = 1'b1; start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        n = 0;
        while (!scan_en_a && n < 10) begin tick(1); n++; end
        check("t5_shifting", 32'(scan_en_a), 32'd1);
        start_a = 1'b1;
        tick(3);
        start_a = 1'b0;
        n = 0;
        while (!done_a && n < 40) begin tick(1); n++; end
        check("t5_done_seen", 32'(done_a), 32'd1);
        check("t5_chain", 32'(chain_a), 32'hA53C);
        tick(4);
        check("t5_words", acc_a, 32'd2);
        check("t5_done_pulses", dones_a, 32'd1);
        check("t5_idle", 32'(busy_a), 32'd0);
        start_a = 1'b1; abort = 1'b1;
        tick(1);
        start_a = 1'b0; abort = 1'b0;
        check("t5_start_abort_busy", 32'(busy_a), 32'd0);
        check("t5_start_abort_ready", 32'(ready_a), 32'd0);
        tick(2);
        check("t5_still_idle", 32'(busy_a), 32'd0);
        check("t5_words_after", acc_a, 32'd2);
        valid = 1'b0;

        // Test 6: reset mid-shift, then a complete load
        restart_src();
        valid = 1'b1; start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        n = 0;
        while (cnt_a != 8'd5 && n < 40) begin tick(1); n++; end
        check("t6_reach_5", 32'(cnt_a), 32'd5);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("t6_rst_flags", 32'({ready_a, scan_en_a, scan_data_a, busy_a, done_a}), 32'd0);
        check("t6_rst_count", 32'(cnt_a), 32'd0);
        restart_src();
        valid = 1'b1; start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        n = 0;
        while (!done_a && n < 40) begin tick(1); n++; end
        check("t6_done_seen", 32'(done_a), 32'd1);
        check("t6_chain", 32'(chain_a), 32'hA53C);
        check("t6_count", 32'(cnt_a), 32'd16);
        valid = 1'b0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
